// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable sequencer: FSM states, run-rate
// select codes and counter widths.
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_t;

  localparam logic [1:0] DIV_SEL_EVERY = 2'b00;
  localparam logic [1:0] DIV_SEL_FAST  = 2'b01;
  localparam logic [1:0] DIV_SEL_SLOW  = 2'b10;
  localparam logic [1:0] DIV_SEL_SLOW2 = 2'b11;

  localparam int CNT_W    = 32;
  localparam int CE_CNT_W = 16;
  localparam int DEB_W    = 20;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output level follows
// the synchronized input only after DEB_CNT consecutive mismatching cycles.
module btn_debounce
  import clk_ctrl_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_CNT = 20'd1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level
);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_level;
  logic [DEB_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_level   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync_p0 <= i_raw;
      r_sync_p1 <= r_sync_p0;
      // debounce stage: a single agreeing cycle restarts the count
      if (r_sync_p1 != r_level) begin
        if (r_cnt == DEB_CNT - 20'd1) begin
          r_level <= r_sync_p1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 20'd1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/step/break sequencer producing a registered one-cycle CPU clock enable;
// the CPU stays on clk and advances only while cpu_ce is high.
module clk_step_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter logic [DEB_W-1:0] DEB_CNT  = 20'd1000000,
  parameter logic [CNT_W-1:0] DIV_FAST = 32'd10,
  parameter logic [CNT_W-1:0] DIV_SLOW = 32'd10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_sw,
  input  logic                step_btn,
  input  logic [1:0]          div_sel,
  input  logic                halt_req,
  output logic                cpu_ce,
  output logic [1:0]          state_o,
  output logic [CE_CNT_W-1:0] ce_count
);

  function automatic logic [CNT_W-1:0] period_of(input logic [1:0] sel);
    case (sel)
      DIV_SEL_EVERY: return 32'd1;
      DIV_SEL_FAST:  return DIV_FAST;
      default:       return DIV_SLOW;
    endcase
  endfunction

  logic                w_run_db;
  logic                w_step_db;
  logic                w_step_pulse;
  logic                w_div_chg;
  logic                w_term;
  logic [CNT_W-1:0]    w_period;

  logic                r_step_db_d;
  logic [1:0]          r_div_sel;
  state_t              r_state;
  logic                r_ce;
  logic [CNT_W-1:0]    r_div_cnt;
  logic [CE_CNT_W-1:0] r_ce_count;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_run_deb (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (run_sw),
    .o_level (w_run_db)
  );

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_step_deb (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (step_btn),
    .o_level (w_step_db)
  );

  assign w_step_pulse = w_step_db & ~r_step_db_d;
  assign w_div_chg    = (div_sel != r_div_sel);
  assign w_period     = period_of(div_sel);
  assign w_term       = (r_div_cnt == w_period - 32'd1);

  // decision stage: cpu_ce and the divider are registered defaults-to-idle,
  // so every branch that leaves them untouched suppresses the enable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_db_d <= 1'b0;
      r_div_sel   <= DIV_SEL_EVERY;
      r_state     <= ST_HALT;
      r_ce        <= 1'b0;
      r_div_cnt   <= '0;
      r_ce_count  <= '0;
    end else begin
      r_step_db_d <= w_step_db;
      r_div_sel   <= div_sel;
      r_ce_count  <= r_ce_count + {{(CE_CNT_W-1){1'b0}}, r_ce};
      r_ce        <= 1'b0;
      r_div_cnt   <= '0;
      case (r_state)
        ST_HALT: begin
          if (w_run_db) begin
            r_state <= ST_RUN;
          end else if (w_step_pulse) begin
            r_state <= ST_STEP;
            r_ce    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            r_state <= ST_BRK;
          end else if (!w_run_db) begin
            r_state <= ST_HALT;
          end else if (!w_div_chg) begin
            if (w_term) begin
              r_ce <= 1'b1;
            end else begin
              r_div_cnt <= r_div_cnt + 32'd1;
            end
          end
        end
        ST_STEP: begin
          r_state <= ST_HALT;
        end
        ST_BRK: begin
          if (!w_run_db) begin
            r_state <= ST_HALT;
          end else if (w_step_pulse) begin
            r_state <= ST_STEP;
            r_ce    <= 1'b1;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign cpu_ce   = r_ce;
  assign state_o  = r_state;
  assign ce_count = r_ce_count;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the run/step/break rules.
module tb_clk_step_ctrl;

  localparam int DEB = 4;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        run_sw   = 1'b0;
  logic        step_btn = 1'b0;
  logic [1:0]  div_sel  = 2'b00;
  logic        halt_req = 1'b0;
  logic        cpu_ce;
  logic [1:0]  state_o;
  logic [15:0] ce_count;

  int n_checks = 0;
  int n_errors = 0;

  clk_step_ctrl #(
    .DEB_CNT  (20'd4),
    .DIV_FAST (32'd3),
    .DIV_SLOW (32'd7)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .div_sel  (div_sel),
    .halt_req (halt_req),
    .cpu_ce   (cpu_ce),
    .state_o  (state_o),
    .ce_count (ce_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // behavioural model: modes 0=halt 1=run 2=step 3=break
  int       m_state, m_ce, m_ce_count, m_age;
  bit       m_run_h1, m_run_h2, m_run_lvl;
  bit       m_stp_h1, m_stp_h2, m_stp_lvl, m_stp_prev;
  int       m_run_mis, m_stp_mis;
  bit [1:0] m_prev_div;

  function automatic int period(input bit [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 3;
    return 7;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ce = 0; m_ce_count = 0; m_age = 0;
    m_run_h1 = 0; m_run_h2 = 0; m_run_lvl = 0; m_run_mis = 0;
    m_stp_h1 = 0; m_stp_h2 = 0; m_stp_lvl = 0; m_stp_mis = 0; m_stp_prev = 0;
    m_prev_div = 2'b00;
  endtask

  // raw input seen two edges late; level flips after DEB straight disagreements
  task automatic deb_step(input bit raw, inout bit h1, inout bit h2, inout bit lvl, inout int mis);
    bit syn;
    syn = h2; h2 = h1; h1 = raw;
    if (syn != lvl) begin
      mis++;
      if (mis == DEB) begin lvl = syn; mis = 0; end
    end else begin
      mis = 0;
    end
  endtask

  task automatic model_step();
    bit pulse, run_db, chg, term;
    int p, ns, nce;
    if (reset) begin model_reset(); return; end
    p      = period(div_sel);
    pulse  = m_stp_lvl && !m_stp_prev;
    run_db = m_run_lvl;
    chg    = (div_sel != m_prev_div);
    term   = ((m_age % p) == p - 1);
    ns     = m_state;
    nce    = 0;
    m_ce_count = (m_ce_count + m_ce) % 65536;
    if (m_state == 1) begin
      if (halt_req) begin ns = 3; m_age = 0; end
      else if (!run_db) begin ns = 0; m_age = 0; end
      else if (chg) m_age = 0;
      else begin
        if (term) nce = 1;
        m_age++;
      end
    end else begin
      m_age = 0;
      if (m_state == 0) begin
        if (run_db) ns = 1;
        else if (pulse) begin ns = 2; nce = 1; end
      end else if (m_state == 2) begin
        ns = 0;
      end else begin
        if (!run_db) ns = 0;
        else if (pulse) begin ns = 2; nce = 1; end
      end
    end
    m_state    = ns;
    m_ce       = nce;
    m_prev_div = div_sel;
    m_stp_prev = m_stp_lvl;
    deb_step(run_sw, m_run_h1, m_run_h2, m_run_lvl, m_run_mis);
    deb_step(step_btn, m_stp_h1, m_stp_h2, m_stp_lvl, m_stp_mis);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("state", {30'd0, state_o}, m_state);
    check("cpu_ce", {31'd0, cpu_ce}, m_ce);
    check("ce_count", {16'd0, ce_count}, m_ce_count);
  endtask

  int n, got, base;

  initial begin
    model_reset();
    repeat (3) tick();
    check("rst_ce", {31'd0, cpu_ce}, 0);
    check("rst_state", {30'd0, state_o}, 0);
    check("rst_count", {16'd0, ce_count}, 0);
    reset = 1'b0;

    // single step from a held button, then a short glitch
    step_btn = 1'b1; n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n += cpu_ce; end
    step_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); n += cpu_ce; end
    check("step_pulses", n, 1);
    check("step_count", {16'd0, ce_count}, 1);
    check("step_state", {30'd0, state_o}, 0);
    step_btn = 1'b1; n = 0;
    repeat (2) begin tick(); n += cpu_ce; end
    step_btn = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); n += cpu_ce; end
    check("glitch_pulses", n, 0);

    // free run at the fast divide
    div_sel = 2'b01; run_sw = 1'b1;
    for (int i = 0; i < 30 && state_o != 2'b01; i++) tick();
    check("run_enter", {30'd0, state_o}, 1);
    repeat (10) tick();
    n = 0; base = ce_count;
    for (int i = 0; i < 30; i++) begin tick(); n += cpu_ce; end
    check("fast_pulses", n, 10);
    check("fast_count_delta", (ce_count - base) & 16'hFFFF, 10);

    // every cycle, then switch to slow mid-run
    div_sel = 2'b00;
    repeat (2) tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin tick(); n += cpu_ce; end
    check("every_pulses", n, 10);
    div_sel = 2'b10;
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (cpu_ce) break; end
    check("slow_first", n, 7);
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (cpu_ce) break; end
    check("slow_gap", n, 7);

    // break request on the cycle a terminal count is due
    for (int i = 0; i < 20; i++) begin
      if (m_state == 1 && (m_age % 7) == 6) break;
      tick();
    end
    check("term_due", m_age % 7, 6);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("brk_ce", {31'd0, cpu_ce}, 0);
    check("brk_state", {30'd0, state_o}, 3);
    n = 0;
    for (int i = 0; i < 30; i++) begin tick(); n += cpu_ce; end
    check("brk_hold_state", {30'd0, state_o}, 3);
    check("brk_hold_pulses", n, 0);

    // step through the break, then resume because run is still high
    step_btn = 1'b1; got = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (cpu_ce) begin got = 1; break; end end
    check("brk_step_seen", got, 1);
    check("brk_step_state", {30'd0, state_o}, 2);
    tick();
    check("brk_step_halt", {30'd0, state_o}, 0);
    tick();
    check("brk_step_rerun", {30'd0, state_o}, 1);
    step_btn = 1'b0;
    repeat (10) tick();

    // drop run while in break
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("brk2_state", {30'd0, state_o}, 3);
    run_sw = 1'b0; n = 0;
    for (int i = 0; i < 30 && state_o != 2'b00; i++) begin tick(); n++; end
    check("brk_drop_lat", n, 7);

    // reset in the middle of a run at count 0x00FF
    run_sw = 1'b1; div_sel = 2'b00;
    for (int i = 0; i < 400 && ce_count != 16'h00FF; i++) tick();
    check("pre_reset_count", {16'd0, ce_count}, 16'h00FF);
    check("pre_reset_state", {30'd0, state_o}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ce", {31'd0, cpu_ce}, 0);
    check("mid_rst_count", {16'd0, ce_count}, 0);
    check("mid_rst_state", {30'd0, state_o}, 0);
    repeat (6) tick();
    check("rerun_wait", {30'd0, state_o}, 0);
    tick();
    check("rerun_enter", {30'd0, state_o}, 1);

    // pulse counter wrap
    for (int i = 0; i < 70000 && ce_count != 16'hFFFF; i++) tick();
    check("count_top", {16'd0, ce_count}, 16'hFFFF);
    tick();
    check("count_wrap", {16'd0, ce_count}, 0);

    // random traffic against the model
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      if (n == 0) begin
        n        = $urandom_range(1, 12);
        run_sw   = ($urandom % 4) != 0;
        step_btn = $urandom % 2;
        if ($urandom % 3 == 0) div_sel = 2'($urandom % 4);
      end
      halt_req = ($urandom % 16) == 0;
      reset    = ($urandom % 500) == 0;
      tick();
      n--;
    end
    reset = 1'b0; halt_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
